clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_core.sv | 54 +++++
 rtl/clk_div_ctrl.sv | 139 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the 32 MHz clock divider: FSM encoding and parameter defaults.
package clk_div_pkg;

    localparam int CNT_W_DEF    = 8;
    localparam int HALF_RST_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN      = 2'b01,
        ST_STOPPING = 2'b10
    } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and divided-clock toggle; ticks are registered on the toggling edge.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_32m,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] half,
    output logic             wrap,
    output logic             div_clk,
    output logic             rise_tick,
    output logic             fall_tick
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic             div_clk_r;
    logic             rise_tick_r;
    logic             fall_tick_r;
    logic             wrap_s;

    // half is never zero, so half-1 cannot underflow
    assign wrap_s = run && (cnt_r == (half - CNT_ONE));

    // Counter, divided clock and edge ticks
    always_ff @(posedge clk_32m) begin
        if (rst || clear || !run) begin
            cnt_r       <= CNT_ZERO;
            div_clk_r   <= 1'b0;
            rise_tick_r <= 1'b0;
            fall_tick_r <= 1'b0;
        end else if (wrap_s) begin
            cnt_r       <= CNT_ZERO;
            div_clk_r   <= ~div_clk_r;
            rise_tick_r <= ~div_clk_r;
            fall_tick_r <= div_clk_r;
        end else begin
            cnt_r       <= cnt_r + CNT_ONE;
            rise_tick_r <= 1'b0;
            fall_tick_r <= 1'b0;
        end
    end

    assign wrap      = wrap_s;
    assign div_clk   = div_clk_r;
    assign rise_tick = rise_tick_r;
    assign fall_tick = fall_tick_r;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: run/stop FSM and half-period config handshake around clk_div_core.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int HALF_RST = HALF_RST_DEF
) (
    input  logic             clk_32m,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HALF_RST_V = CNT_W'(HALF_RST);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] half_active_r;
    logic [CNT_W-1:0] half_pend_r;
    logic             pend_flag_r;
    logic             cfg_err_r;

    logic             core_clear_s;
    logic             core_run_s;
    logic             core_wrap_s;
    logic             div_clk_s;
    logic             accept_s;
    logic             cfg_zero_s;
    logic             rise_edge_s;
    logic             idle_entry_s;

    assign accept_s   = cfg_valid && !pend_flag_r;
    assign cfg_zero_s = (cfg_half == CNT_ZERO);

    // Next-state logic and core control
    always_comb begin
        state_nxt_s  = state_r;
        core_run_s   = 1'b0;
        core_clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                core_clear_s = 1'b1;
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                core_run_s = 1'b1;
                if (stop && !div_clk_s) begin
                    // low phase is cut short; no fall tick is produced
                    core_clear_s = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else if (stop && core_wrap_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (stop) begin
                    state_nxt_s = ST_STOPPING;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STOPPING: begin
                core_run_s = 1'b1;
                if (core_wrap_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOPPING;
                end
            end
            default: begin
                core_clear_s = 1'b1;
                state_nxt_s  = ST_IDLE;
            end
        endcase
    end

    assign rise_edge_s  = core_run_s && !core_clear_s && core_wrap_s && !div_clk_s;
    assign idle_entry_s = (state_r != ST_IDLE) && (state_nxt_s == ST_IDLE);

    // FSM state register
    always_ff @(posedge clk_32m) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Config handshake: immediate load in IDLE, otherwise deferred to a period boundary
    always_ff @(posedge clk_32m) begin
        if (rst) begin
            half_active_r <= HALF_RST_V;
            half_pend_r   <= HALF_RST_V;
            pend_flag_r   <= 1'b0;
            cfg_err_r     <= 1'b0;
        end else begin
            cfg_err_r <= accept_s && cfg_zero_s;
            if (accept_s && !cfg_zero_s && (state_r == ST_IDLE)) begin
                half_active_r <= cfg_half;
            end else if (pend_flag_r && (rise_edge_s || idle_entry_s)) begin
                half_active_r <= half_pend_r;
                pend_flag_r   <= 1'b0;
            end else if (accept_s && !cfg_zero_s) begin
                half_pend_r <= cfg_half;
                pend_flag_r <= 1'b1;
            end
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_32m   (clk_32m),
        .rst       (rst),
        .clear     (core_clear_s),
        .run       (core_run_s),
        .half      (half_active_r),
        .wrap      (core_wrap_s),
        .div_clk   (div_clk_s),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign div_clk   = div_clk_s;
    assign cfg_ready = ~pend_flag_r;
    assign cfg_err   = cfg_err_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with hand-computed phase lengths.
module tb_clk_div_ctrl;

    localparam int CNT_W    = 8;
    localparam int HALF_RST = 8;
    localparam int WAIT_MAX = 600;

    logic             clk_32m = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_clk;
    logic             rise_tick;
    logic             fall_tick;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int n;

    clk_div_ctrl #(
        .CNT_W    (CNT_W),
        .HALF_RST (HALF_RST)
    ) dut (
        .clk_32m   (clk_32m),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .busy      (busy)
    );

    always #5 clk_32m = ~clk_32m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_32m);
        #1;
    endtask

    // cycles until rise_tick is seen (WAIT_MAX on timeout)
    task automatic wait_rise(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!rise_tick && cnt < WAIT_MAX);
    endtask

    task automatic wait_fall(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!fall_tick && cnt < WAIT_MAX);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic do_cfg(input logic [CNT_W-1:0] h);
        cfg_valid = 1'b1;
        cfg_half  = h;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_half = 8'd0;
        step();
        step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_div", div_clk, 0);
        check_eq("rst_rise", rise_tick, 0);
        check_eq("rst_fall", fall_tick, 0);
        check_eq("rst_ready", cfg_ready, 1);
        check_eq("rst_err", cfg_err, 0);
        rst = 1'b0;

        // default half-period 8: 16-cycle period, 50% duty
        do_start();
        check_eq("start_busy", busy, 1);
        check_eq("start_div", div_clk, 0);
        wait_rise(n); check_eq("dflt_first_rise", n, 8);
        wait_fall(n); check_eq("dflt_high", n, 8);
        wait_rise(n); check_eq("dflt_low", n, 8);
        wait_fall(n); check_eq("dflt_high2", n, 8);
        do_stop();
        check_eq("lowstop_busy", busy, 0);
        check_eq("lowstop_div", div_clk, 0);
        check_eq("lowstop_fall", fall_tick, 0);

        // half 3 loaded in IDLE
        do_cfg(8'd3);
        check_eq("cfg3_err", cfg_err, 0);
        check_eq("cfg3_ready", cfg_ready, 1);
        do_start();
        wait_rise(n); check_eq("h3_first_rise", n, 3);
        wait_fall(n); check_eq("h3_high", n, 3);
        wait_rise(n); check_eq("h3_low", n, 3);

        // zero config rejected, period unchanged
        do_cfg(8'd0);
        check_eq("zero_err", cfg_err, 1);
        step();
        check_eq("zero_err_pulse", cfg_err, 0);
        check_eq("zero_ready", cfg_ready, 1);
        wait_fall(n); check_eq("zero_fall", n, 1);
        wait_rise(n); check_eq("zero_low", n, 3);
        wait_fall(n); check_eq("zero_high", n, 3);
        do_stop();
        check_eq("h3_stop_busy", busy, 0);

        // pending config during high phase of half 8
        do_cfg(8'd8);
        do_start();
        wait_rise(n); check_eq("h8_first_rise", n, 8);
        step();
        step();
        do_cfg(8'd2);
        check_eq("pend_ready_lo", cfg_ready, 0);
        wait_fall(n); check_eq("pend_old_high", n, 5);
        wait_rise(n); check_eq("pend_old_low", n, 8);
        check_eq("pend_ready_hi", cfg_ready, 1);
        wait_fall(n); check_eq("h2_high", n, 2);
        wait_rise(n); check_eq("h2_low", n, 2);

        // back to 8 via pending path, then stop 3 cycles into high phase
        do_cfg(8'd8);
        wait_rise(n); check_eq("pend8_rise", n, 3);
        step();
        step();
        do_stop();
        check_eq("hstop_busy", busy, 1);
        check_eq("hstop_div", div_clk, 1);
        wait_fall(n); check_eq("hstop_remaining", n, 5);
        check_eq("hstop_idle", busy, 0);
        check_eq("hstop_div0", div_clk, 0);
        step();
        check_eq("hstop_fall_clr", fall_tick, 0);
        check_eq("hstop_still_idle", busy, 0);

        // start+stop together in RUN, then start during STOPPING
        do_start();
        wait_rise(n); check_eq("ss_rise", n, 8);
        start = 1'b1;
        stop  = 1'b1;
        step();
        stop = 1'b0;
        check_eq("ss_stopping", busy, 1);
        step();
        start = 1'b0;
        wait_fall(n); check_eq("ss_high_rest", n, 6);
        check_eq("ss_idle", busy, 0);
        step();
        step();
        check_eq("ss_no_restart", busy, 0);
        check_eq("ss_div0", div_clk, 0);

        // reset mid-RUN with a pending config
        do_cfg(8'd3);
        do_start();
        wait_rise(n); check_eq("rr_rise", n, 3);
        do_cfg(8'd5);
        check_eq("rr_pending", cfg_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rr_busy", busy, 0);
        check_eq("rr_div", div_clk, 0);
        check_eq("rr_rise0", rise_tick, 0);
        check_eq("rr_fall0", fall_tick, 0);
        check_eq("rr_ready", cfg_ready, 1);
        check_eq("rr_err", cfg_err, 0);
        do_start();
        wait_rise(n); check_eq("rr_half_rst_rise", n, HALF_RST);
        wait_fall(n); check_eq("rr_half_rst_high", n, HALF_RST);
        do_stop();

        // minimum half-period 1; stop at the rise finishes on the next edge
        do_cfg(8'd1);
        do_start();
        wait_rise(n); check_eq("h1_first_rise", n, 1);
        wait_fall(n); check_eq("h1_high", n, 1);
        wait_rise(n); check_eq("h1_low", n, 1);
        do_stop();
        check_eq("h1_stop_fall", fall_tick, 1);
        check_eq("h1_stop_idle", busy, 0);

        // maximum half-period 255
        do_cfg(8'd255);
        do_start();
        wait_rise(n); check_eq("h255_first_rise", n, 255);
        wait_fall(n); check_eq("h255_high", n, 255);
        do_stop();
        check_eq("h255_stop", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
